// File: rtl/sum_capture_fifo.sv
// Capture FIFO for adder results: buffers {carry, sum} on Data_ready and returns them through a
// registered pop/valid handshake with occupancy, sticky error flags and a saturating carry count.
module sum_capture_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] Sum_result,
  input  logic              Sum_carry,
  input  logic              Data_ready,
  input  logic              Rd_req,
  input  logic              Clear,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Rd_carry,
  output logic              Rd_valid,
  output logic [ADDR_W:0]   Fifo_count,
  output logic              Fifo_full,
  output logic              Fifo_empty,
  output logic              Overflow,
  output logic              Underflow,
  output logic [7:0]        Carry_count
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_carry_q, rd_valid_q;
  logic              overflow_q, underflow_q;
  logic [7:0]        carry_cnt_q;
  logic              pop_ok, push_ok;

  // A full FIFO still takes a push when the same cycle frees a slot; an empty one never
  // forwards a same-cycle push to the reader.
  always_comb begin
    pop_ok  = Rd_req && !empty_q;
    push_ok = Data_ready && (!full_q || pop_ok);
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= '0;
      rd_carry_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      carry_cnt_q <= '0;
    end else if (Clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      full_q     <= (count_d == FullCount);
      empty_q    <= (count_d == '0);
      rd_valid_q <= pop_ok;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (Sum_carry && carry_cnt_q != 8'hFF) begin
          carry_cnt_q <= carry_cnt_q + 8'd1;
        end
      end
      if (pop_ok) begin
        rd_ptr_q                <= rd_ptr_q + ADDR_W'(1);
        {rd_carry_q, rd_data_q} <= mem_q[rd_ptr_q];
      end
      if (Data_ready && full_q && !pop_ok) begin
        overflow_q <= 1'b1;
      end
      if (Rd_req && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok && !Clear) begin
      mem_q[wr_ptr_q] <= {Sum_carry, Sum_result};
    end
  end

  assign Rd_data     = rd_data_q;
  assign Rd_carry    = rd_carry_q;
  assign Rd_valid    = rd_valid_q;
  assign Fifo_count  = count_q;
  assign Fifo_full   = full_q;
  assign Fifo_empty  = empty_q;
  assign Overflow    = overflow_q;
  assign Underflow   = underflow_q;
  assign Carry_count = carry_cnt_q;

endmodule
